sal_apb_cfg_slave: RTL and testbench
====================================

Name: sal_apb_cfg_slave

Overview:
APB3 completer for the DDR2 controller's configuration/status register file; it answers the APB master driven by the test bench and the SoC config bus. It holds the DRAM timing parameters and control bits the scheduler consumes, and reports controller status. It adds programmable wait states, decodes word addresses and flags illegal accesses via pslverr.

Parameters:
WAIT_CYCLES, 1, extra access-phase cycles with pready low before completion (0..15)
ID_VALUE, 32'h5344_0200, value returned by the ID register

Ports:
clk  input  1  controller clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
psel  input  1  APB select
penable  input  1  APB enable (access phase)
paddr  input  32  byte address; only [11:0] decoded
pwrite  input  1  1 = write, 0 = read
pwdata  input  32  write data
pready  output  1  transfer completion, registered
prdata  output  32  read data, registered, valid while pready=1
pslverr  output  1  error response, registered, valid while pready=1
init_done_i  input  1  status from DRAM init sequencer
busy_i  input  1  init sequencer busy
init_start_o  output  1  one-cycle pulse requesting DRAM init
refresh_en_o  output  1  CTRL[1]
t_rcd_o, t_rp_o, t_ras_o, t_rc_o  output  8 each  TIMING0 fields
t_rfc_o, t_wr_o  output  8 each  TIMING1 fields
cl_o  output  4  CAS latency, TIMING1[19:16]
t_refi_o  output  16  REFI[15:0]

Behaviour:
- Reset (async, rst_n=0): pready=0, pslverr=0, prdata=0, init_start_o=0, FSM=IDLE, all registers to reset values below. Reset mid-transfer aborts it with no register update.
- Register map (paddr[11:0]); reserved bits read 0, ignore writes:
  0x000 ID RO = ID_VALUE
  0x004 CTRL RW: [0] init_start (write-1 pulse, reads 0), [1] refresh_en; reset 0x0000_0002
  0x008 STATUS RO: [0] init_done_i, [1] busy_i
  0x00C TIMING0 RW: [7:0] t_rcd, [15:8] t_rp, [23:16] t_ras, [31:24] t_rc; reset 0x0B08_0303
  0x010 TIMING1 RW: [7:0] t_rfc, [15:8] t_wr, [19:16] cl; reset 0x0004_031A
  0x014 REFI RW: [15:0] t_refi; reset 0x0000_0C30
  0x018 SCRATCH RW 32 bits; reset 0
- FSM IDLE -> WAIT -> RESP -> IDLE, with a 4-bit wait counter.
  IDLE: psel=1 & penable=0 (setup) captures paddr/pwrite/pwdata; goes to WAIT with cnt=WAIT_CYCLES, or directly to RESP if WAIT_CYCLES=0.
  WAIT: decrement cnt; at cnt=1 go to RESP.
  RESP: pready=1 for exactly one cycle, then IDLE.
- Timing: setup cycle T0, first access cycle T1; pready=1 in cycle T1+WAIT_CYCLES. Transfer completes on the edge where psel & penable & pready are all 1.
- prdata and pslverr are registered in the same cycle as pready. Read value is sampled from register/status state one cycle before pready rises. prdata=0 on writes and on errors; prdata returns to 0 and pslverr to 0 when pready drops.
- Writes commit on the completion edge; outputs reflect the new value in the next cycle.
- pslverr=1, no state change, for: paddr[1:0]!=0; undecoded offset; write to ID or STATUS; CTRL write with pwdata[0]=1 while busy_i=1 (whole write rejected, refresh_en unchanged).
- init_start_o: exactly one cycle high, in the cycle after a committed CTRL write with pwdata[0]=1.
- psel dropping before completion (protocol violation): abort to IDLE, no write, pready stays 0.
- Back-to-back transfers: a new setup may start in the cycle right after RESP; no dead cycle is required beyond the APB setup phase.

Test Plan:
- Reset, WAIT_CYCLES=1: read 0x00C -> pready high in T2, prdata=0x0B08_0303, pslverr=0; read 0x000 -> 0x5344_0200.
- Write 0x014 = 0xFFFF_1234 -> pslverr=0; t_refi_o=16'h1234 the cycle after completion; readback 0x0000_1234.
- Write 0x000 = 0x1; write 0x01C; read 0x006 -> each has pslverr=1 and prdata=0; ID still reads 0x5344_0200.
- Write CTRL=0x3 with busy_i=0 -> single-cycle init_start_o pulse, refresh_en_o=1, CTRL reads 0x2. Repeat with busy_i=1 -> pslverr=1, no pulse.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: write SCRATCH=0xDEAD_BEEF then read it -> pready in T1 and T4 respectively, data 0xDEAD_BEEF.
- Assert rst_n=0 during the WAIT state of a TIMING0 write -> pready=0, TIMING0 reads 0x0B08_0303 after reset.

Source files
------------

// File: rtl/sal_apb_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module   : sal_apb_cfg_slave
// Brief    : APB3 completer for the DDR2 controller configuration/status
//            register file, with programmable wait states and pslverr.
// Revision : 1.0 - initial release
// ============================================================================
module sal_apb_cfg_slave #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h5344_0200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    input  logic        init_done_i,
    input  logic        busy_i,
    output logic        init_start_o,
    output logic        refresh_en_o,
    output logic [7:0]  t_rcd_o,
    output logic [7:0]  t_rp_o,
    output logic [7:0]  t_ras_o,
    output logic [7:0]  t_rc_o,
    output logic [7:0]  t_rfc_o,
    output logic [7:0]  t_wr_o,
    output logic [3:0]  cl_o,
    output logic [15:0] t_refi_o
);

    localparam logic [3:0]  C_WAIT        = 4'(WAIT_CYCLES);
    localparam logic [11:0] C_ADDR_ID     = 12'h000;
    localparam logic [11:0] C_ADDR_CTRL   = 12'h004;
    localparam logic [11:0] C_ADDR_STATUS = 12'h008;
    localparam logic [11:0] C_ADDR_T0     = 12'h00C;
    localparam logic [11:0] C_ADDR_T1     = 12'h010;
    localparam logic [11:0] C_ADDR_REFI   = 12'h014;
    localparam logic [11:0] C_ADDR_SCR    = 12'h018;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;

    logic        refresh_en_q, refresh_en_d;
    logic [31:0] timing0_q, timing0_d;
    logic [19:0] timing1_q, timing1_d;
    logic [15:0] refi_q, refi_d;
    logic [31:0] scratch_q, scratch_d;

    logic        pready_q, pready_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pslverr_q, pslverr_d;
    logic        init_start_q, init_start_d;

    logic [11:0] dec_addr;
    logic        dec_write;
    logic [31:0] dec_wdata;
    logic        dec_hit;
    logic        dec_err;
    logic [31:0] dec_rdata;
    logic        resp_load;
    logic        commit;

    logic        unused_paddr_hi;
    assign unused_paddr_hi = ^paddr[31:12];

    // With zero wait states the response is loaded at the end of the setup
    // cycle, so decode must look at the live bus instead of the capture.
    always_comb begin
        if (state_q == S_IDLE) begin
            dec_addr  = paddr[11:0];
            dec_write = pwrite;
            dec_wdata = pwdata;
        end else begin
            dec_addr  = addr_q;
            dec_write = write_q;
            dec_wdata = wdata_q;
        end
    end

    always_comb begin
        dec_hit   = 1'b1;
        dec_rdata = 32'h0;
        case (dec_addr)
            C_ADDR_ID:     dec_rdata = ID_VALUE;
            C_ADDR_CTRL:   dec_rdata = {30'h0, refresh_en_q, 1'b0};
            C_ADDR_STATUS: dec_rdata = {30'h0, busy_i, init_done_i};
            C_ADDR_T0:     dec_rdata = timing0_q;
            C_ADDR_T1:     dec_rdata = {12'h0, timing1_q};
            C_ADDR_REFI:   dec_rdata = {16'h0, refi_q};
            C_ADDR_SCR:    dec_rdata = scratch_q;
            default:       dec_hit   = 1'b0;
        endcase
        dec_err = !dec_hit
               || (dec_addr[1:0] != 2'b00)
               || (dec_write && ((dec_addr == C_ADDR_ID) || (dec_addr == C_ADDR_STATUS)))
               || (dec_write && (dec_addr == C_ADDR_CTRL) && dec_wdata[0] && busy_i);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        resp_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr[11:0];
                    write_d = pwrite;
                    wdata_d = pwdata;
                    if (C_WAIT == 4'd0) begin
                        state_d   = S_RESP;
                        resp_load = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = C_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d   = S_RESP;
                    resp_load = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign pready_d   = resp_load;
    assign pslverr_d  = resp_load && dec_err;
    assign prdata_d   = (resp_load && !dec_write && !dec_err) ? dec_rdata : 32'h0;
    // Errors were resolved when the response was loaded; commit only on the
    // real completion edge so an abandoned transfer never writes.
    assign commit     = (state_q == S_RESP) && psel && penable && write_q && !pslverr_q;

    always_comb begin
        refresh_en_d = refresh_en_q;
        timing0_d    = timing0_q;
        timing1_d    = timing1_q;
        refi_d       = refi_q;
        scratch_d    = scratch_q;
        init_start_d = 1'b0;
        if (commit) begin
            case (addr_q)
                C_ADDR_CTRL: begin
                    refresh_en_d = wdata_q[1];
                    init_start_d = wdata_q[0];
                end
                C_ADDR_T0:   timing0_d = wdata_q;
                C_ADDR_T1:   timing1_d = wdata_q[19:0];
                C_ADDR_REFI: refi_d    = wdata_q[15:0];
                C_ADDR_SCR:  scratch_d = wdata_q;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 12'h0;
            write_q      <= 1'b0;
            wdata_q      <= 32'h0;
            refresh_en_q <= 1'b1;
            timing0_q    <= 32'h0B08_0303;
            timing1_q    <= 20'h4_031A;
            refi_q       <= 16'h0C30;
            scratch_q    <= 32'h0;
            pready_q     <= 1'b0;
            prdata_q     <= 32'h0;
            pslverr_q    <= 1'b0;
            init_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            refresh_en_q <= refresh_en_d;
            timing0_q    <= timing0_d;
            timing1_q    <= timing1_d;
            refi_q       <= refi_d;
            scratch_q    <= scratch_d;
            pready_q     <= pready_d;
            prdata_q     <= prdata_d;
            pslverr_q    <= pslverr_d;
            init_start_q <= init_start_d;
        end
    end

    assign pready       = pready_q;
    assign prdata       = prdata_q;
    assign pslverr      = pslverr_q;
    assign init_start_o = init_start_q;
    assign refresh_en_o = refresh_en_q;
    assign t_rcd_o      = timing0_q[7:0];
    assign t_rp_o       = timing0_q[15:8];
    assign t_ras_o      = timing0_q[23:16];
    assign t_rc_o       = timing0_q[31:24];
    assign t_rfc_o      = timing1_q[7:0];
    assign t_wr_o       = timing1_q[15:8];
    assign cl_o         = timing1_q[19:16];
    assign t_refi_o     = refi_q;

endmodule
`default_nettype wire

// File: tb/tb_sal_apb_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_sal_apb_cfg_slave
// Brief    : Scoreboard bench for sal_apb_cfg_slave at 0, 1 and 3 wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sal_apb_cfg_slave;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        psel_r    [3];
    logic        penable_r [3];
    logic [31:0] paddr_r   [3];
    logic        pwrite_r  [3];
    logic [31:0] pwdata_r  [3];
    logic        busy_r    [3];
    logic        done_r    [3];

    logic        pready_w  [3];
    logic [31:0] prdata_w  [3];
    logic        pslverr_w [3];
    logic        init_w    [3];
    logic        refen_w   [3];
    logic [7:0]  rcd_w [3], rp_w [3], ras_w [3], rc_w [3], rfc_w [3], wr_w [3];
    logic [3:0]  cl_w      [3];
    logic [15:0] refi_w    [3];

    logic        m_ref [3];
    logic [31:0] m_t0  [3];
    logic [19:0] m_t1  [3];
    logic [15:0] m_refi[3];
    logic [31:0] m_scr [3];

    exp_t q0[$], q1[$], q2[$];
    int n_vec = 0;
    int n_err = 0;

    sal_apb_cfg_slave #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .psel(psel_r[0]), .penable(penable_r[0]),
        .paddr(paddr_r[0]), .pwrite(pwrite_r[0]), .pwdata(pwdata_r[0]),
        .pready(pready_w[0]), .prdata(prdata_w[0]), .pslverr(pslverr_w[0]),
        .init_done_i(done_r[0]), .busy_i(busy_r[0]), .init_start_o(init_w[0]),
        .refresh_en_o(refen_w[0]), .t_rcd_o(rcd_w[0]), .t_rp_o(rp_w[0]),
        .t_ras_o(ras_w[0]), .t_rc_o(rc_w[0]), .t_rfc_o(rfc_w[0]), .t_wr_o(wr_w[0]),
        .cl_o(cl_w[0]), .t_refi_o(refi_w[0]));

    sal_apb_cfg_slave #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .psel(psel_r[1]), .penable(penable_r[1]),
        .paddr(paddr_r[1]), .pwrite(pwrite_r[1]), .pwdata(pwdata_r[1]),
        .pready(pready_w[1]), .prdata(prdata_w[1]), .pslverr(pslverr_w[1]),
        .init_done_i(done_r[1]), .busy_i(busy_r[1]), .init_start_o(init_w[1]),
        .refresh_en_o(refen_w[1]), .t_rcd_o(rcd_w[1]), .t_rp_o(rp_w[1]),
        .t_ras_o(ras_w[1]), .t_rc_o(rc_w[1]), .t_rfc_o(rfc_w[1]), .t_wr_o(wr_w[1]),
        .cl_o(cl_w[1]), .t_refi_o(refi_w[1]));

    sal_apb_cfg_slave #(.WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .psel(psel_r[2]), .penable(penable_r[2]),
        .paddr(paddr_r[2]), .pwrite(pwrite_r[2]), .pwdata(pwdata_r[2]),
        .pready(pready_w[2]), .prdata(prdata_w[2]), .pslverr(pslverr_w[2]),
        .init_done_i(done_r[2]), .busy_i(busy_r[2]), .init_start_o(init_w[2]),
        .refresh_en_o(refen_w[2]), .t_rcd_o(rcd_w[2]), .t_rp_o(rp_w[2]),
        .t_ras_o(ras_w[2]), .t_rc_o(rc_w[2]), .t_rfc_o(rfc_w[2]), .t_wr_o(wr_w[2]),
        .cl_o(cl_w[2]), .t_refi_o(refi_w[2]));

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_ref[d]  = 1'b1;
            m_t0[d]   = 32'h0B08_0303;
            m_t1[d]   = 20'h4_031A;
            m_refi[d] = 16'h0C30;
            m_scr[d]  = 32'h0;
        end
    endtask

    // Expected completion for an access, from the register map rules.
    task automatic model_resp(input int d, input logic [31:0] addr, input logic wr,
                              input logic [31:0] data, output exp_t e);
        int off;
        logic [31:0] val;
        logic known;
        off   = int'(addr[11:0]);
        known = 1'b1;
        val   = 32'h0;
        case (off)
            'h000: val = 32'h5344_0200;
            'h004: val = m_ref[d] ? 32'h2 : 32'h0;
            'h008: val = {30'h0, busy_r[d], done_r[d]};
            'h00C: val = m_t0[d];
            'h010: val = {12'h0, m_t1[d]};
            'h014: val = {16'h0, m_refi[d]};
            'h018: val = m_scr[d];
            default: known = 1'b0;
        endcase
        e.err = !known || (off % 4 != 0) || (wr && (off == 0 || off == 8))
              || (wr && off == 4 && data[0] && busy_r[d]);
        e.data = (wr || e.err) ? 32'h0 : val;
    endtask

    task automatic model_write(input int d, input logic [31:0] addr, input logic [31:0] data);
        case (int'(addr[11:0]))
            'h004: m_ref[d]  = data[1];
            'h00C: m_t0[d]   = data;
            'h010: m_t1[d]   = data[19:0];
            'h014: m_refi[d] = data[15:0];
            'h018: m_scr[d]  = data;
            default: ;
        endcase
    endtask

    task automatic chk_outputs(input int d);
        chk("refresh_en_o", 32'(refen_w[d]), 32'(m_ref[d]));
        chk("timing0_o", {rc_w[d], ras_w[d], rp_w[d], rcd_w[d]}, m_t0[d]);
        chk("timing1_o", {12'h0, cl_w[d], wr_w[d], rfc_w[d]}, {12'h0, m_t1[d]});
        chk("t_refi_o", 32'(refi_w[d]), 32'(m_refi[d]));
    endtask

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic xfer(input int d, input logic [31:0] addr, input logic wr, input logic [31:0] data);
        exp_t e;
        int   k;
        logic pulse;
        model_resp(d, addr, wr, data, e);
        push_exp(d, e);
        @(posedge clk); #1;
        psel_r[d] = 1'b1; penable_r[d] = 1'b0;
        paddr_r[d] = addr; pwrite_r[d] = wr; pwdata_r[d] = data;
        @(posedge clk); #1;
        penable_r[d] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!pready_w[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(wait_of(d)));
        @(posedge clk); #1;
        psel_r[d] = 1'b0; penable_r[d] = 1'b0;
        pulse = wr && !e.err && (addr[11:0] == 12'h004) && data[0];
        if (wr && !e.err) model_write(d, addr, data);
        @(negedge clk);
        chk("init_start_o", 32'(init_w[d]), 32'(pulse));
        chk("pready_drop", 32'(pready_w[d]), 32'h0);
        chk("prdata_idle", prdata_w[d], 32'h0);
        chk("pslverr_idle", 32'(pslverr_w[d]), 32'h0);
        chk_outputs(d);
        if (pulse) begin
            @(negedge clk);
            chk("init_start_width", 32'(init_w[d]), 32'h0);
        end
    endtask

    // Scoreboard monitor: every completion is matched against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (pready_w[d]) begin
                    exp_t e;
                    bit   got;
                    got = 1'b0;
                    e.data = 32'h0;
                    e.err  = 1'b0;
                    case (d)
                        0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                        1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                    endcase
                    if (!got) begin
                        chk("unexpected_pready", 32'd1, 32'd0);
                    end else begin
                        chk("prdata", prdata_w[d], e.data);
                        chk("pslverr", 32'(pslverr_w[d]), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        int          sel;
        int          off;
        int          d;
        int          seen;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            psel_r[i] = 1'b0; penable_r[i] = 1'b0; paddr_r[i] = 32'h0;
            pwrite_r[i] = 1'b0; pwdata_r[i] = 32'h0; busy_r[i] = 1'b0; done_r[i] = 1'b0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_pready", 32'(pready_w[i]), 32'h0);
            chk("rst_prdata", prdata_w[i], 32'h0);
            chk("rst_init_start", 32'(init_w[i]), 32'h0);
            chk_outputs(i);
        end
        @(posedge clk); #1 rst_n = 1'b1;

        xfer(1, 32'h0000_000C, 1'b0, 32'h0);
        xfer(1, 32'h0000_0000, 1'b0, 32'h0);
        xfer(1, 32'h0000_0014, 1'b1, 32'hFFFF_1234);
        xfer(1, 32'h0000_0014, 1'b0, 32'h0);
        xfer(1, 32'h0000_0000, 1'b1, 32'h1);
        xfer(1, 32'h0000_001C, 1'b1, 32'h55);
        xfer(1, 32'h0000_0006, 1'b0, 32'h0);
        xfer(1, 32'h0000_0000, 1'b0, 32'h0);
        xfer(1, 32'h0000_0004, 1'b1, 32'h3);
        xfer(1, 32'h0000_0004, 1'b0, 32'h0);
        busy_r[1] = 1'b1;
        xfer(1, 32'h0000_0004, 1'b1, 32'h3);
        busy_r[1] = 1'b0;
        xfer(0, 32'h0000_0018, 1'b1, 32'hDEAD_BEEF);
        xfer(0, 32'h0000_0018, 1'b0, 32'h0);
        xfer(2, 32'h0000_0018, 1'b1, 32'hDEAD_BEEF);
        xfer(2, 32'h0000_0018, 1'b0, 32'h0);

        for (int n = 0; n < 150; n++) begin
            d   = int'($urandom_range(0, 2));
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       off = sel * 4;
            else if (sel == 8) off = 4 * int'($urandom_range(0, 6)) + int'($urandom_range(1, 3));
            else               off = int'($urandom_range(32, 4095)) & ~3;
            a = ($urandom() & 32'hFFFF_F000) | 32'(off);
            busy_r[d] = 1'($urandom_range(0, 1));
            done_r[d] = 1'($urandom_range(0, 1));
            xfer(d, a, 1'($urandom_range(0, 1)), $urandom());
        end

        // psel withdrawn during wait states: no completion, no write.
        @(posedge clk); #1;
        psel_r[2] = 1'b1; penable_r[2] = 1'b0; paddr_r[2] = 32'h18;
        pwrite_r[2] = 1'b1; pwdata_r[2] = 32'hA5A5_A5A5;
        @(posedge clk); #1 penable_r[2] = 1'b1;
        @(posedge clk); #1 begin psel_r[2] = 1'b0; penable_r[2] = 1'b0; end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (pready_w[2]) seen++;
        end
        chk("abort_pready", 32'(seen), 32'h0);
        xfer(2, 32'h0000_0018, 1'b0, 32'h0);

        // Reset during the wait state of a TIMING0 write.
        @(posedge clk); #1;
        psel_r[2] = 1'b1; penable_r[2] = 1'b0; paddr_r[2] = 32'h0C;
        pwrite_r[2] = 1'b1; pwdata_r[2] = 32'h1234_5678;
        @(posedge clk); #1 penable_r[2] = 1'b1;
        @(negedge clk); #2 rst_n = 1'b0;
        #1 chk("rst_mid_pready", 32'(pready_w[2]), 32'h0);
        psel_r[2] = 1'b0; penable_r[2] = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        xfer(2, 32'h0000_000C, 1'b0, 32'h0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(q0.size() + q1.size() + q2.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
